multi_channel_bounce_counter: RTL and testbench



---
 rtl/bounce_pkg.sv | 16 +
 rtl/bounce_channel.sv | 157 +++++++++++++++
 rtl/multi_channel_bounce_counter.sv | 72 +++++++
 tb/tb_multi_channel_bounce_counter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bounce_pkg.sv
// Shared types and width helpers for the multi-channel bounce counter.
// Optional feature macro: BOUNCE_CNT_SAT_EN (saturating counters + sat flags).
package bounce_pkg;

  typedef enum logic [1:0] {
    ZERO,
    WAIT1,
    ONE,
    WAIT0
  } deb_state_t;

  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bounce_channel.sv
// One switch channel: synchroniser, debounce FSM, edge detectors, counters.
// Optional feature macro: BOUNCE_CNT_SAT_EN (saturating counters + sat flag).
module bounce_channel
  import bounce_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int DB_TICKS    = 2_000_000,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sw,
  input  logic             clr,
  output logic             db,
  output logic [CNT_W-1:0] raw_cnt,
  output logic [CNT_W-1:0] db_cnt,
  output logic             sat
);

  localparam int TW = clog2_min1(DB_TICKS);
  localparam logic [TW-1:0] TLAST = TW'(DB_TICKS - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_lvl_q;
  logic                   r_db;
  logic                   r_db_q;
  deb_state_t             r_state;
  deb_state_t             w_next;
  logic [TW-1:0]          r_timer;
  logic [TW-1:0]          w_timer_nxt;
  logic [CNT_W-1:0]       r_raw;
  logic [CNT_W-1:0]       r_dbc;
  logic                   w_lvl;
  logic                   w_raw_tick;
  logic                   w_db_tick;

  assign w_lvl      = r_sync[SYNC_STAGES-1];
  assign w_raw_tick = w_lvl & ~r_lvl_q;
  assign w_db_tick  = r_db & ~r_db_q;

  // Shift the raw switch through the synchroniser chain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_sync <= '0;
    else        r_sync <= {r_sync[SYNC_STAGES-2:0], sw};
  end

  // Level history for both rising-edge detectors.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lvl_q <= 1'b0;
      r_db_q  <= 1'b0;
    end else begin
      r_lvl_q <= w_lvl;
      r_db_q  <= r_db;
    end
  end

  // Debounce state, timer and registered db decode.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ZERO;
      r_timer <= '0;
      r_db    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_timer <= w_timer_nxt;
      r_db    <= (w_next == ONE) || (w_next == WAIT0);
    end
  end

  // Next state: a level must hold DB_TICKS timer steps to be accepted.
  always_comb begin
    w_next      = r_state;
    w_timer_nxt = r_timer;
    unique case (r_state)
      ZERO: begin
        if (w_lvl) begin
          w_next      = WAIT1;
          w_timer_nxt = '0;
        end
      end
      WAIT1: begin
        if (!w_lvl) begin
          w_next = ZERO;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
          if (r_timer == TLAST) w_next = ONE;
        end
      end
      ONE: begin
        if (!w_lvl) begin
          w_next      = WAIT0;
          w_timer_nxt = '0;
        end
      end
      WAIT0: begin
        if (w_lvl) begin
          w_next = ONE;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
          if (r_timer == TLAST) w_next = ZERO;
        end
      end
    endcase
  end

`ifdef BOUNCE_CNT_SAT_EN
  localparam logic [CNT_W-1:0] CMAX = '1;
  logic r_sat;

  // Saturating edge counters; clr overrides any tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_raw <= '0;
      r_dbc <= '0;
    end else if (clr) begin
      r_raw <= '0;
      r_dbc <= '0;
    end else begin
      if (w_raw_tick && r_raw != CMAX) r_raw <= r_raw + 1'b1;
      if (w_db_tick && r_dbc != CMAX)  r_dbc <= r_dbc + 1'b1;
    end
  end

  // Sticky flag: a tick arrived while a counter was pinned at max.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    r_sat <= 1'b0;
    else if (clr)  r_sat <= 1'b0;
    else if ((w_raw_tick && r_raw == CMAX) ||
             (w_db_tick && r_dbc == CMAX))
      r_sat <= 1'b1;
  end

  assign sat = r_sat;
`else
  // Wrapping edge counters; clr overrides any tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_raw <= '0;
      r_dbc <= '0;
    end else if (clr) begin
      r_raw <= '0;
      r_dbc <= '0;
    end else begin
      if (w_raw_tick) r_raw <= r_raw + 1'b1;
      if (w_db_tick)  r_dbc <= r_dbc + 1'b1;
    end
  end

  assign sat = 1'b0;
`endif

  assign db      = r_db;
  assign raw_cnt = r_raw;
  assign db_cnt  = r_dbc;

endmodule

// File: rtl/multi_channel_bounce_counter.sv
// Multi-channel bounce counter: per-channel debounce plus registered count mux.
// Optional feature macro: BOUNCE_CNT_SAT_EN (saturating counters + sat flags).
module multi_channel_bounce_counter
  import bounce_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int CNT_W       = 8,
  parameter int DB_TICKS    = 2_000_000,
  parameter int SYNC_STAGES = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [CHANNELS-1:0]               sw,
  input  logic [CHANNELS-1:0]               clr,
  input  logic [clog2_min1(CHANNELS)-1:0]   sel,
  output logic [CHANNELS-1:0]               db,
  output logic [CNT_W-1:0]                  raw_count,
  output logic [CNT_W-1:0]                  db_count,
  output logic [CHANNELS-1:0]               sat
);

  logic [CNT_W-1:0] w_raw [CHANNELS];
  logic [CNT_W-1:0] w_dbc [CHANNELS];
  logic [CNT_W-1:0] w_raw_sel;
  logic [CNT_W-1:0] w_dbc_sel;
  logic [CNT_W-1:0] r_raw_count;
  logic [CNT_W-1:0] r_db_count;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    bounce_channel #(
      .CNT_W      (CNT_W),
      .DB_TICKS   (DB_TICKS),
      .SYNC_STAGES(SYNC_STAGES)
    ) u_ch (
      .clk    (clk),
      .reset  (reset),
      .sw     (sw[g]),
      .clr    (clr[g]),
      .db     (db[g]),
      .raw_cnt(w_raw[g]),
      .db_cnt (w_dbc[g]),
      .sat    (sat[g])
    );
  end

  // Select a channel; out-of-range selects fall back to channel 0.
  always_comb begin
    w_raw_sel = w_raw[0];
    w_dbc_sel = w_dbc[0];
    for (int i = 1; i < CHANNELS; i++) begin
      if (int'(sel) == i) begin
        w_raw_sel = w_raw[i];
        w_dbc_sel = w_dbc[i];
      end
    end
  end

  // Register the selected counts for the display path.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_raw_count <= '0;
      r_db_count  <= '0;
    end else begin
      r_raw_count <= w_raw_sel;
      r_db_count  <= w_dbc_sel;
    end
  end

  assign raw_count = r_raw_count;
  assign db_count  = r_db_count;

endmodule

// File: tb/tb_multi_channel_bounce_counter.sv
// Bench for multi_channel_bounce_counter: cycle model plus directed literals.
// Three channels so that an out-of-range select value can be exercised.
module tb_multi_channel_bounce_counter;

  localparam int CH   = 3;
  localparam int W    = 4;
  localparam int T    = 4;
  localparam int S    = 2;
  localparam int MAXV = (1 << W) - 1;
`ifdef BOUNCE_CNT_SAT_EN
  localparam int SATON = 1;
`else
  localparam int SATON = 0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [CH-1:0] sw;
  logic [CH-1:0] clr;
  logic [1:0]    sel;
  logic [CH-1:0] db;
  logic [W-1:0]  raw_count;
  logic [W-1:0]  db_count;
  logic [CH-1:0] sat;

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  multi_channel_bounce_counter #(
    .CHANNELS(CH), .CNT_W(W), .DB_TICKS(T), .SYNC_STAGES(S)
  ) dut (
    .clk(clk), .reset(reset), .sw(sw), .clr(clr), .sel(sel),
    .db(db), .raw_count(raw_count), .db_count(db_count), .sat(sat)
  );

  // Model: sw history (hist[j] = sw sampled j+1 edges ago), db flips once
  // the synced level has disagreed with it on T+1 consecutive edges.
  logic [S:0] m_hist [CH];
  bit         m_db   [CH];
  bit         m_dbp  [CH];
  int         m_run  [CH];
  int         m_rc   [CH];
  int         m_dc   [CH];
  bit         m_sat  [CH];
  int         m_ro, m_do;

  always @(posedge clk or negedge reset) begin : model
    int  s;
    bit  lv, lp, rt, dt;
    if (!reset) begin
      for (int c = 0; c < CH; c++) begin
        m_hist[c] = '0; m_db[c] = 0; m_dbp[c] = 0; m_run[c] = 0;
        m_rc[c] = 0; m_dc[c] = 0; m_sat[c] = 0;
      end
      m_ro = 0; m_do = 0;
    end else begin
      s = (int'(sel) < CH) ? int'(sel) : 0;
      m_ro = m_rc[s];
      m_do = m_dc[s];
      for (int c = 0; c < CH; c++) begin
        lv = m_hist[c][S-1];
        lp = m_hist[c][S];
        rt = lv & !lp;
        dt = m_db[c] & !m_dbp[c];
        m_dbp[c] = m_db[c];
        if (lv != m_db[c]) begin
          m_run[c]++;
          if (m_run[c] == T + 1) begin
            m_db[c] = lv;
            m_run[c] = 0;
          end
        end else begin
          m_run[c] = 0;
        end
        m_hist[c] = {m_hist[c][S-1:0], sw[c]};
        if (clr[c]) begin
          m_rc[c] = 0; m_dc[c] = 0; m_sat[c] = 0;
        end else begin
          if (SATON == 1) begin
            if (rt) begin
              if (m_rc[c] == MAXV) m_sat[c] = 1; else m_rc[c]++;
            end
            if (dt) begin
              if (m_dc[c] == MAXV) m_sat[c] = 1; else m_dc[c]++;
            end
          end else begin
            if (rt) m_rc[c] = (m_rc[c] + 1) % (MAXV + 1);
            if (dt) m_dc[c] = (m_dc[c] + 1) % (MAXV + 1);
          end
        end
      end
    end
  end

  task automatic cmp(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic press(input int c, input int hi, input int lo);
    sw[c] = 1'b1;
    step(hi);
    sw[c] = 1'b0;
    step(lo);
  endtask

  task automatic pulse_clr(input logic [CH-1:0] m);
    clr = m;
    step(1);
    clr = '0;
    step(1);
  endtask

  initial begin
    sw    = '0;
    clr   = '0;
    sel   = '0;
    reset = 1'b0;

    fork
      forever begin : compare
        int mdb, msat;
        @(negedge clk);
        mdb = 0; msat = 0;
        for (int c = 0; c < CH; c++) begin
          mdb  |= int'(m_db[c]) << c;
          msat |= int'(m_sat[c]) << c;
        end
        cmp("model_db", int'(db), mdb);
        cmp("model_raw", int'(raw_count), m_ro);
        cmp("model_dbc", int'(db_count), m_do);
        cmp("model_sat", int'(sat), msat);
      end
    join_none

    #23;
    cmp("rst_raw", int'(raw_count), 0);
    cmp("rst_db", int'(db), 0);
    reset = 1'b1;
    step(2);

    // 1: clean press, latency of raw and db paths
    sw[0] = 1'b1;
    step(3);
    cmp("t1_raw_edge3", int'(raw_count), 0);
    step(1);
    cmp("t1_raw_edge4", int'(raw_count), 1);
    step(2);
    cmp("t1_db_edge6", int'(db[0]), 0);
    step(1);
    cmp("t1_db_edge7", int'(db[0]), 1);
    step(3);
    cmp("t1_raw", int'(raw_count), 1);
    cmp("t1_dbc", int'(db_count), 1);
    sw[0] = 1'b0;
    step(10);
    pulse_clr(3'b001);

    // 2: bounce 1,0,1,0,1 then held
    for (int i = 0; i < 5; i++) begin
      sw[0] = (i % 2 == 0);
      step(1);
    end
    step(12);
    cmp("t2_raw", int'(raw_count), 3);
    cmp("t2_dbc", int'(db_count), 1);
    sw[0] = 1'b0;
    step(10);
    pulse_clr(3'b001);

    // 3: 17 presses on channel 1 -> wrap or saturate
    sel = 2'd1;
    for (int i = 0; i < 17; i++) press(1, 8, 8);
    step(2);
    cmp("t3_raw", int'(raw_count), (SATON == 1) ? 15 : 1);
    cmp("t3_dbc", int'(db_count), (SATON == 1) ? 15 : 1);
    cmp("t3_sat1", int'(sat[1]), SATON);
    pulse_clr(3'b010);
    step(1);
    cmp("t3_clr_raw", int'(raw_count), 0);
    cmp("t3_clr_sat", int'(sat[1]), 0);

    // 4: clr coincident with a raw tick at count 5
    sel = 2'd0;
    step(1);
    for (int i = 0; i < 5; i++) press(0, 8, 8);
    cmp("t4_pre", int'(raw_count), 5);
    sw[0] = 1'b1;
    step(2);
    clr[0] = 1'b1;
    step(1);
    clr[0] = 1'b0;
    step(1);
    cmp("t4_clr_tick", int'(raw_count), 0);
    step(10);
    sw[0] = 1'b0;
    step(10);
    pulse_clr(3'b001);

    // 5: asynchronous reset mid-count
    for (int i = 0; i < 6; i++) press(0, 8, 8);
    sw[0] = 1'b1;
    step(10);
    cmp("t5_pre_raw", int'(raw_count), 7);
    cmp("t5_pre_db", int'(db[0]), 1);
    #1 reset = 1'b0;
    #1;
    cmp("t5_async_raw", int'(raw_count), 0);
    cmp("t5_async_dbc", int'(db_count), 0);
    cmp("t5_async_db", int'(db), 0);
    cmp("t5_async_sat", int'(sat), 0);
    #2 reset = 1'b1;
    step(6);
    cmp("t5_resume_raw", int'(raw_count), 1);
    sw[0] = 1'b0;
    step(10);

    // 6: independence and select
    pulse_clr(3'b011);
    press(0, 8, 8);
    press(1, 8, 8);
    press(0, 8, 8);
    press(1, 8, 8);
    press(0, 8, 8);
    cmp("t6_sel0", int'(raw_count), 3);
    sel = 2'd1;
    #2;
    cmp("t6_sel1_hold", int'(raw_count), 3);
    step(1);
    cmp("t6_sel1_raw", int'(raw_count), 2);
    cmp("t6_sel1_dbc", int'(db_count), 2);
    sel = 2'd2;
    step(1);
    cmp("t6_sel2", int'(raw_count), 0);
    sel = 2'd3;
    step(1);
    cmp("t6_sel3_raw", int'(raw_count), 3);
    cmp("t6_sel3_dbc", int'(db_count), 3);
    step(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
